// File: rtl/vip_ycbcr444_rgb888.sv
// vip_ycbcr444_rgb888
// Pipelined YCbCr444 -> RGB888 converter (BT.601 full range, x1024 fixed point).
// Fixed latency of 3 clocks; camera-style framing travels alongside the data.
// Also counts valid output pixels per frame and reports the total at vsync fall.
//
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   per_frame_vsync/href/clken  input framing
//   per_img_Y/Cb/Cr             input pixel (Cb/Cr offset 128)
//   post_frame_vsync/href/clken framing delayed by 3 clocks
//   post_img_red/green/blue     clamped RGB, forced to 0 outside href
//   frame_pixel_cnt             valid-pixel count of the last completed frame
//   frame_done                  one-clock pulse when frame_pixel_cnt updates
module vip_ycbcr444_rgb888 #(
    parameter int unsigned CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [7:0]       per_img_Y,
    input  logic [7:0]       per_img_Cb,
    input  logic [7:0]       per_img_Cr,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [7:0]       post_img_red,
    output logic [7:0]       post_img_green,
    output logic [7:0]       post_img_blue,
    output logic [CNT_W-1:0] frame_pixel_cnt,
    output logic             frame_done
);

    // Signed chroma offsets and stage-1 operands
    logic signed [8:0]  cb_s, cr_s;
    logic signed [20:0] cb_w, cr_w, y_w;

    assign cb_s = $signed({1'b0, per_img_Cb}) - 9'sd128;
    assign cr_s = $signed({1'b0, per_img_Cr}) - 9'sd128;
    assign cb_w = 21'(cb_s);
    assign cr_w = 21'(cr_s);
    assign y_w  = $signed({3'b000, per_img_Y, 10'b0});

    // Stage 1: scaled luma and the four chroma products
    logic signed [20:0] y_s1_q, r_cr_s1_q, g_cb_s1_q, g_cr_s1_q, b_cb_s1_q;
    // Stage 2: rounded sums
    logic signed [20:0] r_s2_q, g_s2_q, b_s2_q;
    // Stage 3: shifted and clamped
    logic [7:0] red_s3_q, green_s3_q, blue_s3_q;

    logic [2:0] vsync_sr_q, href_sr_q, clken_sr_q;

    // Negative sums clamp to 0; anything at or above 256*1024 clamps to 255.
    function automatic logic [7:0] clamp8(input logic signed [20:0] s);
        if (s[20]) begin
            return 8'h00;
        end else if (|s[19:18]) begin
            return 8'hff;
        end else begin
            return s[17:10];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            y_s1_q     <= '0;
            r_cr_s1_q  <= '0;
            g_cb_s1_q  <= '0;
            g_cr_s1_q  <= '0;
            b_cb_s1_q  <= '0;
            r_s2_q     <= '0;
            g_s2_q     <= '0;
            b_s2_q     <= '0;
            red_s3_q   <= '0;
            green_s3_q <= '0;
            blue_s3_q  <= '0;
            vsync_sr_q <= '0;
            href_sr_q  <= '0;
            clken_sr_q <= '0;
        end else begin
            y_s1_q     <= y_w;
            r_cr_s1_q  <= cr_w * 21'sd1436;
            g_cb_s1_q  <= cb_w * 21'sd352;
            g_cr_s1_q  <= cr_w * 21'sd731;
            b_cb_s1_q  <= cb_w * 21'sd1815;
            r_s2_q     <= y_s1_q + r_cr_s1_q + 21'sd512;
            g_s2_q     <= y_s1_q - g_cb_s1_q - g_cr_s1_q + 21'sd512;
            b_s2_q     <= y_s1_q + b_cb_s1_q + 21'sd512;
            red_s3_q   <= clamp8(r_s2_q);
            green_s3_q <= clamp8(g_s2_q);
            blue_s3_q  <= clamp8(b_s2_q);
            vsync_sr_q <= {vsync_sr_q[1:0], per_frame_vsync};
            href_sr_q  <= {href_sr_q[1:0], per_frame_href};
            clken_sr_q <= {clken_sr_q[1:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vsync_sr_q[2];
    assign post_frame_href  = href_sr_q[2];
    assign post_frame_clken = clken_sr_q[2];
    assign post_img_red     = post_frame_href ? red_s3_q   : 8'h00;
    assign post_img_green   = post_frame_href ? green_s3_q : 8'h00;
    assign post_img_blue    = post_frame_href ? blue_s3_q  : 8'h00;

    // Per-frame pixel counter
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             vsync_prev_q;
    logic             pix_valid, vsync_fall;

    assign pix_valid  = post_frame_href & post_frame_clken;
    assign vsync_fall = vsync_prev_q & ~post_frame_vsync;

    always_comb begin
        cnt_inc = cnt_q;
        if (pix_valid && !(&cnt_q)) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= '0;
            vsync_prev_q    <= 1'b0;
            frame_pixel_cnt <= '0;
            frame_done      <= 1'b0;
        end else begin
            vsync_prev_q <= post_frame_vsync;
            frame_done   <= vsync_fall;
            if (vsync_fall) begin
                // Latched total includes a pixel valid in the fall cycle itself
                frame_pixel_cnt <= cnt_inc;
                cnt_q           <= '0;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

endmodule
